mul_iter: RTL and testbench

- Iterative, parameterised radix-4 Booth multiplier for the MDU; the multi-cycle successor to the single-shot two-stage multiplier.
- Retires DPC radix-4 digits per cycle, so area and latency trade through one parameter.
- Adds a start/busy/done handshake, flush abort, and RV64 word ops (MULW) with early termination.
- Produces the final XLEN-bit architectural result rather than a raw double-width product.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/booth_r4_digit.sv | 27 ++
 rtl/mul_iter.sv | 165 ++++++++++++++++
 tb/tb_mul_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: Funct3 encodings, the
// iterative multiplier state type and its iteration-count helper.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mulstate_t;

    // Number of BUSY cycles: radix-4 digits covering the widened operand, DPC per cycle.
    function automatic int mul_iters(input int xlen, input int dpc, input logic word);
        int digits;
        digits = word ? 17 : (xlen + 2) / 2;
        return (digits + dpc - 1) / dpc;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: a 3-bit multiplier window selects 0, +-A or +-2A
// of the widened multiplicand.
module booth_r4_digit #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      window,
    input  logic [XLEN+1:0] multA,
    output logic [XLEN+2:0] partial
);

    logic [XLEN+2:0] oneA;
    logic [XLEN+2:0] twoA;

    assign oneA = {multA[XLEN+1], multA};
    assign twoA = {multA, 1'b0};

    always_comb begin
        case (window)
            3'b001, 3'b010: partial = oneA;
            3'b011:         partial = twoA;
            3'b100:         partial = -twoA;
            3'b101, 3'b110: partial = -oneA;
            default:        partial = '0;
        endcase
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-4 Booth multiplier retiring DPC digits per BUSY cycle,
// with start/busy/done handshake, flush abort and RV64 MULW support.
module mul_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int DPC  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic            StallM,
    input  logic [2:0]      Funct3E,
    input  logic            WordE,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            BusyE,
    output logic            DoneM,
    output logic [XLEN-1:0] ResultM
);

    localparam int EW    = XLEN + 2;
    localparam int PPW   = XLEN + 3;
    localparam int CSW   = PPW + 2 * (DPC - 1);
    localparam int AW    = 2 * XLEN + 4;
    localparam int BW    = EW + 2 * DPC;
    localparam int NFULL = mul_iters(XLEN, DPC, 1'b0);
    localparam int NWORD = mul_iters(XLEN, DPC, 1'b1);
    localparam int CNTW  = $clog2(NFULL + 1);

    mulstate_t             state;
    logic [EW-1:0]         multA;
    logic [BW-1:0]         multB;
    logic                  bPrev;
    logic [2:0]            funct3Q;
    logic                  wordQ;
    logic [CNTW-1:0]       iterCnt;
    logic signed [AW-1:0]  acc;

    logic                  wordIn;
    logic                  signA;
    logic                  signB;
    logic [EW-1:0]         extA;
    logic [EW-1:0]         extB;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        wordIn = (XLEN == 64) && WordE;
        signA  = (Funct3E == F3_MULH) || (Funct3E == F3_MULHSU);
        signB  = (Funct3E == F3_MULH);
        extA   = {{2{signA & ForwardedSrcAE[XLEN-1]}}, ForwardedSrcAE};
        extB   = {{2{signB & ForwardedSrcBE[XLEN-1]}}, ForwardedSrcBE};
        if (wordIn) begin
            extA = EW'(signed'(ForwardedSrcAE[31:0]));
            extB = EW'(signed'(ForwardedSrcBE[31:0]));
        end
    end

    logic [2*DPC:0]  bWin;
    logic [2:0]      window  [DPC];
    logic [PPW-1:0]  partial [DPC];
    int              numDigits;

    // Windows overlap by one bit; bPrev carries the bit just below the current LSB.
    always_comb begin
        numDigits = wordQ ? 17 : EW / 2;
        bWin      = {multB[2*DPC-1:0], bPrev};
        for (int j = 0; j < DPC; j++) begin
            window[j] = bWin[2*j +: 3];
            if (int'(iterCnt) * DPC + j >= numDigits) window[j] = 3'b000;
        end
    end

    for (genvar g = 0; g < DPC; g++) begin : gen_digit
        booth_r4_digit #(.XLEN(XLEN)) u_digit (
            .window  (window[g]),
            .multA   (multA),
            .partial (partial[g])
        );
    end

    logic signed [CSW-1:0] cycleSum;
    logic signed [AW-1:0]  accNext;
    logic [XLEN-1:0]       resultSel;
    int                    iterLimit;
    logic                  lastIter;

    always_comb begin
        cycleSum = '0;
        for (int j = 0; j < DPC; j++) begin
            cycleSum = cycleSum + (CSW'(signed'(partial[j])) <<< (2 * j));
        end
        accNext = acc + (AW'(cycleSum) <<< (2 * DPC * int'(iterCnt)));

        if (wordQ)                    resultSel = XLEN'(signed'(accNext[31:0]));
        else if (funct3Q == F3_MUL)   resultSel = accNext[XLEN-1:0];
        else                          resultSel = accNext[2*XLEN-1:XLEN];

        iterLimit = wordQ ? NWORD : NFULL;
        lastIter  = (int'(iterCnt) == iterLimit - 1);
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            BusyE   <= 1'b0;
            DoneM   <= 1'b0;
            ResultM <= '0;
            multA   <= '0;
            multB   <= '0;
            bPrev   <= 1'b0;
            funct3Q <= '0;
            wordQ   <= 1'b0;
            iterCnt <= '0;
            acc     <= '0;
        end else if (FlushE) begin
            // ResultM keeps its stale value; DoneM=0 marks it invalid.
            state <= IDLE;
            BusyE <= 1'b0;
            DoneM <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE) begin
                        state   <= BUSY;
                        BusyE   <= 1'b1;
                        multA   <= extA;
                        multB   <= BW'(signed'(extB));
                        bPrev   <= 1'b0;
                        funct3Q <= Funct3E;
                        wordQ   <= wordIn;
                        iterCnt <= '0;
                        acc     <= '0;
                    end
                end
                BUSY: begin
                    acc     <= accNext;
                    multB   <= BW'(signed'(multB) >>> (2 * DPC));
                    bPrev   <= multB[2*DPC-1];
                    iterCnt <= iterCnt + CNTW'(1);
                    if (lastIter) begin
                        state   <= DONE;
                        DoneM   <= 1'b1;
                        ResultM <= resultSel;
                    end
                end
                DONE: begin
                    if (!StallM) begin
                        state <= IDLE;
                        BusyE <= 1'b0;
                        DoneM <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BusyE <= 1'b0;
                    DoneM <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: four configurations (32/DPC2, 64/DPC2, 64/DPC1,
// 64/DPC4) share stimulus; results, latency and handshake are checked.
module tb_mul_iter;
    import mdu_pkg::*;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE, FlushE, StallM, WordE;
    logic [2:0]  Funct3E;
    logic [63:0] srcA, srcB;
    logic [NDUT-1:0] busy, done;
    logic [31:0] res32;
    logic [63:0] res1, res2, res3;

    int checks = 0;
    int errors = 0;
    int lat [NDUT];

    always #5 clk = ~clk;

    mul_iter #(.XLEN(32), .DPC(2)) dut32 (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE), .StallM(StallM),
        .Funct3E(Funct3E), .WordE(WordE), .ForwardedSrcAE(srcA[31:0]), .ForwardedSrcBE(srcB[31:0]),
        .BusyE(busy[0]), .DoneM(done[0]), .ResultM(res32));
    mul_iter #(.XLEN(64), .DPC(2)) dut64d2 (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE), .StallM(StallM),
        .Funct3E(Funct3E), .WordE(WordE), .ForwardedSrcAE(srcA), .ForwardedSrcBE(srcB),
        .BusyE(busy[1]), .DoneM(done[1]), .ResultM(res1));
    mul_iter #(.XLEN(64), .DPC(1)) dut64d1 (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE), .StallM(StallM),
        .Funct3E(Funct3E), .WordE(WordE), .ForwardedSrcAE(srcA), .ForwardedSrcBE(srcB),
        .BusyE(busy[2]), .DoneM(done[2]), .ResultM(res2));
    mul_iter #(.XLEN(64), .DPC(4)) dut64d4 (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE), .StallM(StallM),
        .Funct3E(Funct3E), .WordE(WordE), .ForwardedSrcAE(srcA), .ForwardedSrcBE(srcB),
        .BusyE(busy[3]), .DoneM(done[3]), .ResultM(res3));

    function automatic int xl(input int i);
        return (i == 0) ? 32 : 64;
    endfunction

    function automatic int dp(input int i);
        case (i)
            0, 1:    return 2;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] res_of(input int i);
        case (i)
            0:       return {32'b0, res32};
            1:       return res1;
            2:       return res2;
            default: return res3;
        endcase
    endfunction

    // Plain wide-integer reference, independent of the Booth recoding.
    function automatic logic [63:0] ref_mul(input int xlen, input logic [2:0] f3, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] pa, pb, p;
        logic sa, sb;
        sa = (f3 == F3_MULH) || (f3 == F3_MULHSU);
        sb = (f3 == F3_MULH);
        if (xlen == 32) begin
            if (sa) pa = 130'(signed'(a[31:0])); else pa = 130'(a[31:0]);
            if (sb) pb = 130'(signed'(b[31:0])); else pb = 130'(b[31:0]);
            p = pa * pb;
            return (f3 == F3_MUL) ? {32'b0, p[31:0]} : {32'b0, p[63:32]};
        end
        if (word) begin
            pa = 130'(signed'(a[31:0]));
            pb = 130'(signed'(b[31:0]));
            p  = pa * pb;
            return 64'(signed'(p[31:0]));
        end
        if (sa) pa = 130'(signed'(a)); else pa = 130'(a);
        if (sb) pb = 130'(signed'(b)); else pb = 130'(b);
        p = pa * pb;
        return (f3 == F3_MUL) ? p[63:0] : p[127:64];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic chkRes);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s/busy%0d", tag, i), 64'(busy[i]), 64'd0);
            check($sformatf("%s/done%0d", tag, i), 64'(done[i]), 64'd0);
            if (chkRes) check($sformatf("%s/res%0d", tag, i), res_of(i), 64'd0);
        end
    endtask

    // Drive one start pulse, then scramble the inputs to prove operand capture.
    task automatic launch(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        Funct3E = f3; WordE = w; srcA = a; srcB = b; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        Funct3E = f3 ^ 3'b011; WordE = ~w; srcA = ~a; srcB = ~b;
    endtask

    task automatic wait_done(input string tag, input logic w, input int skipped);
        bit seen [NDUT];
        int nseen = 0;
        for (int i = 0; i < NDUT; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
        end
        for (int cyc = skipped + 1; cyc <= 80 && nseen < NDUT; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (!seen[i] && done[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = cyc;
                    nseen++;
                end
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s/lat%0d", tag, i), 64'(lat[i]),
                  64'(mul_iters(xl(i), dp(i), w && (xl(i) == 64))));
        end
    endtask

    task automatic check_res(input string tag, input logic [63:0] e32, input logic [63:0] e64, input logic chk64);
        check({tag, "/res0"}, res_of(0), {32'b0, e32[31:0]});
        if (chk64) begin
            for (int i = 1; i < NDUT; i++) check($sformatf("%s/res%0d", tag, i), res_of(i), e64);
        end
    endtask

    task automatic release_stall(input string tag);
        StallM = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check($sformatf("%s/drop%0d", tag, i), 64'(done[i]), 64'd0);
        StallM = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] e32, input logic [63:0] e64, input logic chk64);
        launch(f3, w, a, b);
        wait_done(tag, w, 0);
        check_res(tag, e32, e64, chk64);
        release_stall(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pool [8];
        logic [63:0] a, b;
        reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; StallM = 1'b1;
        WordE = 1'b0; Funct3E = F3_MUL; srcA = '0; srcB = '0;
        pool = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                 64'h0000_0000_7FFF_FFFF};

        repeat (2) @(negedge clk);
        check_idle("reset", 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 1'b1);

        // Basic ops; the 32-bit instance sees only the low halves.
        run_op("mul_neg", F3_MUL, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        check("mul_neg/lat32_is9",  64'(lat[0]), 64'd9);
        check("mul_neg/lat64d2_is17", 64'(lat[1]), 64'd17);
        check("mul_neg/lat64d1_is33", 64'(lat[2]), 64'd33);
        run_op("mulhu_ones", F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        run_op("mulh_min", F3_MULH, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
               64'h4000_0000, 64'h0, 1'b1);
        run_op("mulhsu_ones", F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // MULW: upper operand bits ignored, result sign-extended from bit 31.
        run_op("mulw", F3_MUL, 1'b1, 64'h7FFF_FFFF, 64'h2,
               64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check("mulw/lat64d2_is9",  64'(lat[1]), 64'd9);
        check("mulw/lat64d1_is17", 64'(lat[2]), 64'd17);
        run_op("mulw_hi", F3_MUL, 1'b1, 64'hDEAD_BEEF_0000_0005, 64'h1234_5678_FFFF_FFFD,
               64'hFFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);

        // Flush after five iterations, then a fresh op.
        launch(F3_MUL, 1'b0, 64'd123, 64'd456);
        for (int i = 0; i < NDUT; i++) check($sformatf("busy_after_start%0d", i), 64'(busy[i]), 64'd1);
        repeat (5) @(negedge clk);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check_idle("flush_busy", 1'b0);
        repeat (40) @(negedge clk);
        check_idle("flush_quiet", 1'b0);
        run_op("mulhu_x2", F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 64'h1, 1'b1);

        // Flush and start together in IDLE: flush wins.
        FlushE = 1'b1; StartE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0; StartE = 1'b0;
        check_idle("flush_start", 1'b0);

        // Stall hold, start ignored while busy, start ignored on DONE->IDLE.
        launch(F3_MUL, 1'b0, 64'h1234_5678, 64'h10);
        @(negedge clk);
        Funct3E = F3_MULHU; srcA = 64'h1; srcB = 64'h1; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        wait_done("stall", 1'b0, 2);
        check_res("stall", 64'h2345_6780, 64'h1_2345_6780, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) check($sformatf("stall_hold%0d/done%0d", k, i), 64'(done[i]), 64'd1);
            check_res($sformatf("stall_hold%0d", k), 64'h2345_6780, 64'h1_2345_6780, 1'b1);
        end
        StallM = 1'b0; StartE = 1'b1; Funct3E = F3_MUL; WordE = 1'b0; srcA = 64'd5; srcB = 64'd5;
        @(negedge clk);
        check_idle("stall_release", 1'b0);
        StartE = 1'b0; StallM = 1'b1;
        @(negedge clk);
        check_idle("no_start_on_exit", 1'b0);

        // Flush in DONE while stalled discards DoneM but leaves ResultM alone.
        launch(F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3);
        wait_done("flush_done", 1'b0, 0);
        check_res("flush_done", 64'h2, 64'h2, 1'b1);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check_idle("flush_done_idle", 1'b0);
        check_res("flush_done_kept", 64'h2, 64'h2, 1'b1);

        // Reset mid-BUSY.
        launch(F3_MULH, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_busy", 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset_busy_after", 1'b1);

        // Random and boundary operands against the reference model.
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 2; w++) begin
                for (int n = 0; n < 24; n++) begin
                    if ($urandom_range(0, 3) == 0) a = pool[$urandom_range(0, 7)];
                    else a = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) b = pool[$urandom_range(0, 7)];
                    else b = {$urandom, $urandom};
                    run_op($sformatf("rnd_f%0d_w%0d_%0d", f, w, n), 3'(f), 1'(w), a, b,
                           ref_mul(32, 3'(f), 1'b0, a, b), ref_mul(64, 3'(f), 1'(w), a, b),
                           (w == 0) || (f == 0));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
